// File: rtl/key_input_conditioner.sv
// Keypad front-end: two-flop synchroniser, tick-based debounce, press/release/
// long-press pulses, per-key pending bits and a small ordered event queue with
// a valid/ready handshake. Downstream logic uses only the clean outputs.
module key_input_conditioner #(
  parameter int N_KEYS     = 12,
  parameter int DEB_TICKS  = 4,
  parameter int LONG_TICKS = 100,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic [N_KEYS-1:0] key_raw,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic              evt_valid,
  output logic [3:0]        evt_code,
  output logic              evt_long,
  input  logic              evt_ready,
  output logic              evt_overflow,
  input  logic              ovf_clr
);

  localparam int CODE_W = 4;
  localparam int N_SRC  = 2 * N_KEYS;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = PTR_W + 1;

  localparam logic [3:0]       DEB_LAST  = 4'(DEB_TICKS - 1);
  localparam logic [9:0]       HOLD_LAST = 10'(LONG_TICKS - 1);
  localparam logic [9:0]       HOLD_MAX  = 10'(LONG_TICKS);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);

  logic [N_KEYS-1:0] sync_meta;
  logic [N_KEYS-1:0] sync_s;
  logic [3:0]        deb_cnt  [N_KEYS];
  logic [9:0]        hold_cnt [N_KEYS];

  // Pending bits: [N_KEYS-1:0] are press events, [N_SRC-1:N_KEYS] long events.
  logic [N_SRC-1:0]  pend_q;
  logic [N_SRC-1:0]  pend_set;
  logic [N_SRC-1:0]  grant;
  logic [N_SRC-1:0]  grant_eff;
  logic              req_any;
  logic [CODE_W-1:0] req_code;
  logic              req_long;

  logic [CODE_W:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   fifo_cnt;
  logic               fifo_full;
  logic               push;
  logic               pop;
  logic [CODE_W:0]    head;

  // Two-flop synchroniser on every raw pin.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_meta <= '0;
      sync_s    <= '0;
    end else begin
      // NOTE: state is updated with <= so every flop samples pre-edge values;
      // with = the second stage would see this cycle's first stage and the
      // synchroniser would collapse to one flop.
      sync_meta <= key_raw;
      sync_s    <= sync_meta;
    end
  end

  // Debounce: a level change is accepted after DEB_TICKS disagreeing ticks.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) deb_cnt[i] <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
    end else begin
      key_press   <= '0;
      key_release <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (sync_s[i] == key_level[i]) begin
          deb_cnt[i] <= '0;
        end else if (tick) begin
          if (deb_cnt[i] == DEB_LAST) begin
            key_level[i]   <= ~key_level[i];
            key_press[i]   <= ~key_level[i];
            key_release[i] <= key_level[i];
            deb_cnt[i]     <= '0;
          end else begin
            deb_cnt[i] <= deb_cnt[i] + 4'd1;
          end
        end
      end
    end
  end

  // Hold timer: saturates at LONG_TICKS so a hold yields exactly one long pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) hold_cnt[i] <= '0;
      key_long <= '0;
    end else begin
      key_long <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        if (!key_level[i]) begin
          hold_cnt[i] <= '0;
        end else if (tick && (hold_cnt[i] != HOLD_MAX)) begin
          hold_cnt[i] <= hold_cnt[i] + 10'd1;
          if (hold_cnt[i] == HOLD_LAST) key_long[i] <= 1'b1;
        end
      end
    end
  end

  assign pend_set  = {key_long, key_press};
  assign fifo_full = (fifo_cnt == CNT_FULL);
  assign pop       = (fifo_cnt != '0) && evt_ready;
  assign push      = req_any && !fifo_full;
  assign grant_eff = push ? grant : '0;

  // Fixed-priority arbiter: lowest pending index wins (presses before longs).
  always_comb begin
    // NOTE: every output of this block gets a default before the loop;
    // otherwise the paths where nothing is pending would infer latches.
    grant    = '0;
    req_any  = 1'b0;
    req_code = '0;
    req_long = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!req_any && pend_q[i]) begin
        req_any  = 1'b1;
        grant[i] = 1'b1;
        if (i < N_KEYS) begin
          req_code = CODE_W'(i);
          req_long = 1'b0;
        end else begin
          req_code = CODE_W'(i - N_KEYS);
          req_long = 1'b1;
        end
      end
    end
  end

  // Pending bits and sticky overflow; a bit granted this cycle is not lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_q       <= '0;
      evt_overflow <= 1'b0;
    end else begin
      pend_q <= (pend_q & ~grant_eff) | pend_set;
      if (|(pend_set & pend_q & ~grant_eff)) evt_overflow <= 1'b1;
      else if (ovf_clr)                      evt_overflow <= 1'b0;
    end
  end

  // Queue storage: written on push only.
  always_ff @(posedge clk) begin
    // NOTE: the storage array has no reset; emptiness is tracked by the
    // pointers and count, and stale entries are never presented as valid.
    if (push) fifo_mem[wr_ptr] <= {req_long, req_code};
  end

  // Queue pointers and occupancy; fullness uses the count before this edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + CNT_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CNT_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign head      = fifo_mem[rd_ptr];
  assign evt_valid = (fifo_cnt != '0);
  assign evt_code  = evt_valid ? head[CODE_W-1:0] : '0;
  assign evt_long  = evt_valid ? head[CODE_W] : 1'b0;

endmodule

// File: tb/tb_key_input_conditioner.sv
// Directed bench for key_input_conditioner with the default parameters.
module tb_key_input_conditioner;

  localparam int N_KEYS = 12;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              tick;
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_level;
  logic [N_KEYS-1:0] key_press;
  logic [N_KEYS-1:0] key_release;
  logic [N_KEYS-1:0] key_long;
  logic              evt_valid;
  logic [3:0]        evt_code;
  logic              evt_long;
  logic              evt_ready;
  logic              evt_overflow;
  logic              ovf_clr;

  int checks = 0;
  int errors = 0;

  int press_cnt [N_KEYS];
  int rel_cnt   [N_KEYS];
  int long_cnt  [N_KEYS];
  logic [4:0] evlog [$];

  int t4_keys [5] = '{1, 2, 3, 4, 6};
  int t4_next [4] = '{2, 3, 4, 6};

  key_input_conditioner dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .key_raw      (key_raw),
    .key_level    (key_level),
    .key_press    (key_press),
    .key_release  (key_release),
    .key_long     (key_long),
    .evt_valid    (evt_valid),
    .evt_code     (evt_code),
    .evt_long     (evt_long),
    .evt_ready    (evt_ready),
    .evt_overflow (evt_overflow),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  // Pulse counters and accepted-event log, sampled mid-cycle.
  always @(negedge clk) begin
    for (int i = 0; i < N_KEYS; i++) begin
      press_cnt[i] += int'(key_press[i]);
      rel_cnt[i]   += int'(key_release[i]);
      long_cnt[i]  += int'(key_long[i]);
    end
    if (rst_n && evt_valid && evt_ready) evlog.push_back({evt_long, evt_code});
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clk cycle with the given tick value; returns 1 time unit after the edge.
  task automatic cyc(input logic t);
    tick = t;
    @(posedge clk);
    #1;
    tick = 1'b0;
  endtask

  // n ticks, each preceded by three idle cycles.
  task automatic tick_cycles(input int n);
    repeat (n) begin
      cyc(1'b0); cyc(1'b0); cyc(1'b0); cyc(1'b1);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    tick      = 1'b0;
    key_raw   = '0;
    evt_ready = 1'b0;
    ovf_clr   = 1'b0;

    // Reset, with tick toggling (must be ignored).
    cyc(1'b1); cyc(1'b1); cyc(1'b1);
    check("rst_level",  key_level, 0);
    check("rst_pulses", {key_press, key_release, key_long}, 0);
    check("rst_evt",    {evt_valid, evt_long, evt_code, evt_overflow}, 0);
    rst_n = 1'b1;
    cyc(1'b0); cyc(1'b0);

    // 1: bouncing key 9, then a stable press.
    for (int s = 0; s < 6; s++) begin
      key_raw[9] = (s % 2 == 0);
      tick_cycles(2);
    end
    check("t1_bounce_level", key_level[9], 1'b0);
    check("t1_bounce_press", press_cnt[9], 0);
    key_raw[9] = 1'b1;
    tick_cycles(3);
    check("t1_level_3ticks", key_level[9], 1'b0);
    tick_cycles(1);
    check("t1_level_4ticks", key_level[9], 1'b1);
    check("t1_press_pulse",  key_press, 12'h200);
    cyc(1'b0);
    check("t1_press_1cyc",   key_press, 12'h000);
    check("t1_valid_lat1",   evt_valid, 1'b0);
    cyc(1'b0);
    check("t1_valid_lat2",   evt_valid, 1'b1);
    check("t1_event",        {evt_long, evt_code}, 5'h09);
    evt_ready = 1'b1;
    cyc(1'b0);
    check("t1_popped",       evt_valid, 1'b0);
    check("t1_press_count",  press_cnt[9], 1);
    key_raw[9] = 1'b0;
    tick_cycles(5);
    check("t1_release_count", rel_cnt[9], 1);

    // 2: long hold of key 10.
    evlog.delete();
    key_raw[10] = 1'b1;
    tick_cycles(103);
    check("t2_level",         key_level[10], 1'b1);
    check("t2_no_long_yet",   long_cnt[10], 0);
    check("t2_press_evt_n",   evlog.size(), 1);
    check("t2_press_evt",     evlog[0], 5'h0A);
    tick_cycles(1);
    check("t2_long_pulse",    key_long, 12'h400);
    cyc(1'b0);
    check("t2_long_1cyc",     key_long, 12'h000);
    tick_cycles(20);
    check("t2_long_count",    long_cnt[10], 1);
    key_raw[10] = 1'b0;
    tick_cycles(4);
    check("t2_release_pulse", key_release, 12'h400);
    check("t2_level_low",     key_level[10], 1'b0);
    tick_cycles(2);
    check("t2_evt_count",     evlog.size(), 2);
    check("t2_long_evt",      evlog[1], 5'h1A);

    // 3: keys 0, 5, 11 in the same cycle.
    evlog.delete();
    key_raw = 12'h821;
    tick_cycles(4);
    check("t3_press_pulse", key_press, 12'h821);
    repeat (8) cyc(1'b0);
    check("t3_evt_count", evlog.size(), 3);
    check("t3_evt0",      evlog[0], 5'h00);
    check("t3_evt1",      evlog[1], 5'h05);
    check("t3_evt2",      evlog[2], 5'h0B);
    key_raw = '0;
    tick_cycles(5);

    // 4: fill the queue, one pending, overflow on re-press, ordered drain.
    evt_ready = 1'b0;
    evlog.delete();
    for (int k = 0; k < 5; k++) begin
      key_raw[t4_keys[k]] = 1'b1;
      tick_cycles(4);
      key_raw[t4_keys[k]] = 1'b0;
      tick_cycles(4);
    end
    check("t4_head",     {evt_valid, evt_long, evt_code}, 6'h21);
    check("t4_no_ovf",   evt_overflow, 1'b0);
    key_raw[6] = 1'b1;
    tick_cycles(4);
    check("t4_repress",  key_press, 12'h040);
    cyc(1'b0);
    check("t4_ovf_set",  evt_overflow, 1'b1);
    key_raw[6] = 1'b0;
    tick_cycles(4);
    evt_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0);
      check("t4_drain", {evt_valid, evt_long, evt_code}, 32'(6'h20 | t4_next[k]));
    end
    cyc(1'b0);
    check("t4_empty",    evt_valid, 1'b0);
    check("t4_drain_n",  evlog.size(), 5);
    check("t4_ovf_stky", evt_overflow, 1'b1);
    ovf_clr = 1'b1;
    cyc(1'b0);
    ovf_clr = 1'b0;
    check("t4_ovf_clr",  evt_overflow, 1'b0);

    // 5: push and pop together at count 2.
    evt_ready = 1'b0;
    key_raw[8:7] = 2'b11;
    tick_cycles(4);
    repeat (3) cyc(1'b0);
    check("t5_head7", {evt_valid, evt_code}, 5'h17);
    key_raw[8:7] = 2'b00;
    tick_cycles(5);
    key_raw[0] = 1'b1;
    tick_cycles(4);
    check("t5_press0", key_press, 12'h001);
    cyc(1'b0);
    evt_ready = 1'b1;
    cyc(1'b0);
    evt_ready = 1'b0;
    check("t5_head8", {evt_valid, evt_code}, 5'h18);
    cyc(1'b0);
    check("t5_hold8", {evt_valid, evt_code}, 5'h18);
    evt_ready = 1'b1;
    cyc(1'b0);
    check("t5_head0", {evt_valid, evt_long, evt_code}, 6'h20);
    cyc(1'b0);
    check("t5_empty", evt_valid, 1'b0);
    evt_ready = 1'b0;
    key_raw[0] = 1'b0;
    tick_cycles(5);

    // 6: reset with queue non-empty and key 3 held.
    key_raw[3] = 1'b1;
    tick_cycles(4);
    repeat (3) cyc(1'b0);
    check("t6_head3", {evt_valid, evt_code}, 5'h13);
    rst_n = 1'b0;
    cyc(1'b1);
    check("t6_rst_level", key_level, 0);
    check("t6_rst_evt",   {evt_valid, evt_long, evt_code, evt_overflow}, 0);
    check("t6_rst_pulse", {key_press, key_release, key_long}, 0);
    cyc(1'b1);
    rst_n = 1'b1;
    tick_cycles(3);
    check("t6_level_3ticks", key_level[3], 1'b0);
    tick_cycles(1);
    check("t6_repress",      key_press, 12'h008);
    cyc(1'b0); cyc(1'b0);
    check("t6_fresh_evt",    {evt_valid, evt_long, evt_code}, 6'h23);
    key_raw[3] = 1'b0;
    evt_ready  = 1'b1;
    tick_cycles(5);
    check("t6_drained",      evt_valid, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
